// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter
// Description : Round-robin scheduler sharing one 5-stage (a+b)*c multiplier
//               among N requesters. Issue order is recorded in a tag FIFO so
//               returning products can be routed back to their requester.
//               Each requester may have at most MAX_OUT operations in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
    parameter int N       = 4,
    parameter int MAX_OUT = 2,
    parameter int DEPTH   = 8,
    parameter int IDW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    // requester side
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*47-1:0]     req_a,
    input  logic [N*47-1:0]     req_b,
    input  logic [N*48-1:0]     req_c,
    // multiplier side
    output logic                mul_in_valid,
    output logic [46:0]         mul_in_1,
    output logic [46:0]         mul_in_2,
    output logic [47:0]         mul_in_3,
    input  logic                mul_out_valid,
    input  logic [95:0]         mul_out,
    // response side
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [95:0]         rsp_data,
    output logic                busy,
    output logic                err
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int C_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // FIFO slot index
    localparam int C_CNT_W  = $clog2(DEPTH + 1);                // FIFO occupancy 0..DEPTH
    localparam int C_OUT_W  = $clog2(MAX_OUT + 1);              // per-requester 0..MAX_OUT
    localparam int C_SCAN_W = IDW + 1;                          // ptr+offset before wrap

    localparam logic [C_CNT_W-1:0]  c_DEPTH     = C_CNT_W'(DEPTH);
    localparam logic [C_OUT_W-1:0]  c_MAX_OUT   = C_OUT_W'(MAX_OUT);
    localparam logic [C_PTR_W-1:0]  c_LAST_SLOT = C_PTR_W'(DEPTH - 1);
    localparam logic [IDW-1:0]      c_LAST_ID   = IDW'(N - 1);
    localparam logic [C_SCAN_W-1:0] c_N_EXT     = C_SCAN_W'(N);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDW-1:0]      r_ptr;                 // round-robin start index
    logic [C_OUT_W-1:0]  r_cnt [N];             // outstanding ops per requester

    logic [IDW-1:0]      r_tag_mem [DEPTH];     // issue-order tag FIFO
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic [C_CNT_W-1:0]  r_count;

    logic                r_mul_in_valid;
    logic [46:0]         r_mul_in_1;
    logic [46:0]         r_mul_in_2;
    logic [47:0]         r_mul_in_3;

    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic [95:0]         r_rsp_data;
    logic                r_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [N-1:0]        w_elig;
    logic                w_gnt_any;
    logic [IDW-1:0]      w_gnt_id;
    logic [C_SCAN_W-1:0] w_scan;
    logic [46:0]         w_sel_a;
    logic [46:0]         w_sel_b;
    logic [47:0]         w_sel_c;
    logic                w_push;
    logic                w_pop;
    logic                w_spurious;
    logic [IDW-1:0]      w_head;

    assign w_fifo_full  = (r_count == c_DEPTH);
    assign w_fifo_empty = (r_count == '0);

    // Eligibility is judged on pre-edge state only: a pop in the same cycle
    // does not free a slot or an outstanding credit until the next cycle.
    for (genvar gi = 0; gi < N; gi++) begin : g_elig
        assign w_elig[gi] = req_valid[gi] && (r_cnt[gi] < c_MAX_OUT) && !w_fifo_full;
    end

    // Round-robin scan: first eligible index starting at r_ptr, modulo N.
    // The wrap is a single conditional subtract since ptr+offset < 2N.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_scan    = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_ptr} + C_SCAN_W'(k);
            if (w_scan >= c_N_EXT) begin
                w_scan = w_scan - c_N_EXT;
            end
            if (!w_gnt_any && w_elig[w_scan[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_scan[IDW-1:0];
            end
        end
    end

    // One-hot grant; forced low while reset is asserted so the port reads 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign req_ready[gi] = !rst && w_gnt_any && (w_gnt_id == IDW'(gi));
    end

    // Operand mux: pick the granted requester's slices.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_c = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_sel_a = req_a[i*47 +: 47];
                w_sel_b = req_b[i*47 +: 47];
                w_sel_c = req_c[i*48 +: 48];
            end
        end
    end

    assign w_push     = w_gnt_any && !rst;
    assign w_pop      = mul_out_valid && !w_fifo_empty;
    assign w_spurious = mul_out_valid && w_fifo_empty;
    assign w_head     = r_tag_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Advance the round-robin pointer past the requester just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + IDW'(1);
        end
    end

    // Tag FIFO storage: write the granted id at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_gnt_id;
        end
    end

    // Tag FIFO pointers and occupancy; push+pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_SLOT) ? '0 : r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_SLOT) ? '0 : r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    // Per-requester outstanding counters; a grant and a return for the same
    // requester in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((w_push && (w_gnt_id == IDW'(i))) && !(w_pop && (w_head == IDW'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + C_OUT_W'(1);
                end else if ((w_pop && (w_head == IDW'(i))) && !(w_push && (w_gnt_id == IDW'(i)))) begin
                    r_cnt[i] <= r_cnt[i] - C_OUT_W'(1);
                end
            end
        end
    end

    // Multiplier input registers; operands hold when nothing is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_in_valid <= 1'b0;
            r_mul_in_1     <= '0;
            r_mul_in_2     <= '0;
            r_mul_in_3     <= '0;
        end else begin
            r_mul_in_valid <= w_push;
            if (w_push) begin
                r_mul_in_1 <= w_sel_a;
                r_mul_in_2 <= w_sel_b;
                r_mul_in_3 <= w_sel_c;
            end
        end
    end

    // Response registers: product and owning id appear the cycle after return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_id   <= w_head;
                r_rsp_data <= mul_out;
            end
        end
    end

    // Sticky error: a product arrived with no tag waiting for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_spurious) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mul_in_valid = r_mul_in_valid;
    assign mul_in_1     = r_mul_in_1;
    assign mul_in_2     = r_mul_in_2;
    assign mul_in_3     = r_mul_in_3;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign busy         = !w_fifo_empty;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arbiter
// Description : Self-checking bench for mul_arbiter. A behavioural 5-stage
//               (a+b)*c multiplier closes the loop; a reference model of the
//               arbitration rules predicts grants and a scoreboard predicts
//               every response (id, data, arrival cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;

    localparam int N       = 4;
    localparam int MAX_OUT = 2;
    localparam int DEPTH   = 8;
    localparam int IDW     = $clog2(N);
    localparam int LAT     = 7;   // accept edge -> rsp_valid cycle

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*47-1:0]    req_a;
    logic [N*47-1:0]    req_b;
    logic [N*48-1:0]    req_c;
    logic               mul_in_valid;
    logic [46:0]        mul_in_1;
    logic [46:0]        mul_in_2;
    logic [47:0]        mul_in_3;
    logic               mul_out_valid;
    logic [95:0]        mul_out;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [95:0]        rsp_data;
    logic               busy;
    logic               err;

    logic               force_v;
    logic [95:0]        force_d;

    int                 cyc = 0;
    int                 total = 0;
    int                 bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_arbiter #(.N(N), .MAX_OUT(MAX_OUT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_c         (req_c),
        .mul_in_valid  (mul_in_valid),
        .mul_in_1      (mul_in_1),
        .mul_in_2      (mul_in_2),
        .mul_in_3      (mul_in_3),
        .mul_out_valid (mul_out_valid),
        .mul_out       (mul_out),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .err           (err)
    );

    // Behavioural multiplier: 5 register stages, reset together with the DUT.
    logic [4:0]  mv;
    logic [95:0] md [5];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= '0;
            for (int k = 0; k < 5; k++) md[k] <= '0;
        end else begin
            mv    <= {mv[3:0], mul_in_valid};
            md[0] <= (96'(mul_in_1) + 96'(mul_in_2)) * 96'(mul_in_3);
            for (int k = 1; k < 5; k++) md[k] <= md[k-1];
        end
    end
    assign mul_out_valid = mv[4] | force_v;
    assign mul_out       = force_v ? force_d : md[4];

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [95:0]    data;
        int             due;
    } exp_t;

    exp_t        exp_q[$];      // expected responses in order
    int          inflight[$];   // ids issued and not yet returned by the multiplier
    int          m_ptr;
    bit          m_err;
    bit          m_in_valid;
    logic [46:0] m_a;
    logic [46:0] m_b;
    logic [47:0] m_c;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int outstanding(input int id);
        int n = 0;
        foreach (inflight[j]) if (inflight[j] == id) n++;
        return n;
    endfunction

    // Issue-side monitor: predict the grant from the arbitration rules,
    // check issue-side outputs, then advance the model by this cycle's events.
    always @(negedge clk) begin
        int          g;
        logic [N-1:0] want_rdy;
        logic [46:0] a;
        logic [46:0] b;
        logic [47:0] c;
        exp_t        e;
        if (rst) begin
            chk("ready_in_reset", req_ready, '0);
            chk("in_valid_in_reset", mul_in_valid, '0);
            chk("in_ops_in_reset", {mul_in_1, mul_in_2, mul_in_3}, '0);
            chk("busy_in_reset", busy, '0);
            chk("err_in_reset", err, '0);
            m_ptr      = 0;
            m_err      = 1'b0;
            m_in_valid = 1'b0;
            m_a        = '0;
            m_b        = '0;
            m_c        = '0;
            inflight.delete();
        end else begin
            g = -1;
            if (inflight.size() < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (g < 0 && req_valid[i] && outstanding(i) < MAX_OUT) g = i;
                end
            end
            want_rdy = '0;
            if (g >= 0) want_rdy[g] = 1'b1;
            chk("req_ready", req_ready, want_rdy);
            chk("busy", busy, inflight.size() != 0);
            chk("err", err, m_err);
            chk("mul_in_valid", mul_in_valid, m_in_valid);
            chk("mul_in_ops", {mul_in_1, mul_in_2, mul_in_3}, {m_a, m_b, m_c});

            if (mul_out_valid) begin
                if (inflight.size() > 0) void'(inflight.pop_front());
                else m_err = 1'b1;
            end
            if (g >= 0) begin
                a = req_a[g*47 +: 47];
                b = req_b[g*47 +: 47];
                c = req_c[g*48 +: 48];
                inflight.push_back(g);
                m_ptr  = (g + 1) % N;
                m_a    = a;
                m_b    = b;
                m_c    = c;
                e.id   = IDW'(g);
                e.data = (96'(a) + 96'(b)) * 96'(c);
                e.due  = cyc + LAT;
                exp_q.push_back(e);
            end
            m_in_valid = (g >= 0);
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        bit   want;
        exp_t e;
        if (rst) begin
            chk("rsp_in_reset", {rsp_valid, rsp_id, rsp_data}, '0);
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rsp_valid", rsp_valid, want);
            if (want && rsp_valid) begin
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*47 +: 47] = 47'({$urandom, $urandom});
            req_b[i*47 +: 47] = 47'({$urandom, $urandom});
            req_c[i*48 +: 48] = 48'({$urandom, $urandom});
        end
    endtask

    initial begin
        rst       = 1'b1;
        force_v   = 1'b0;
        force_d   = '0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i*47 +: 47] = 47'(i);
            req_b[i*47 +: 47] = 47'(1);
            req_c[i*48 +: 48] = 48'(10);
        end

        // Reset with all requests high, then fairness sweep from requester 0.
        repeat (4) step();
        rst = 1'b0;
        repeat (20) step();
        req_valid = '0;
        repeat (12) step();

        // Single op from requester 2: (3+4)*5.
        req_a[2*47 +: 47] = 47'(3);
        req_b[2*47 +: 47] = 47'(4);
        req_c[2*48 +: 48] = 48'(5);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (10) step();

        // Outstanding limit: requester 1 alone, continuously.
        rand_ops();
        req_valid = 4'b0010;
        repeat (12) step();
        req_valid = '0;
        repeat (10) step();

        // Spurious return while idle.
        force_d = 96'hABC;
        force_v = 1'b1;
        step();
        force_v = 1'b0;
        repeat (4) step();

        // Reset with three ops in flight, then a fresh op from requester 3.
        rand_ops();
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_ops();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        repeat (10) step();

        // Random traffic.
        repeat (400) begin
            rand_ops();
            req_valid = N'($urandom | $urandom);
            step();
        end
        req_valid = '0;
        repeat (12) step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
